beam_delay_scheduler: RTL and testbench
=======================================

// Module: beam_delay_scheduler
// PURPOSE
// - Steering controller for the delay-and-sum beamformer.
// - Accepts a steering-angle request and looks up one delay per mic channel.
// - Stages those delays in a shadow register, then commits them to every channel's delay line at once, on a PCM sample boundary.
// - After a commit, holds data-valid low until the delay-line buffers have flushed stale samples.
// PARAMETERS
// - NUM_CH          4   number of mic channels / delay lines driven
// - NUM_ANGLES      8   number of steering table entries
// - ANGLE_W         3   width of angle index (clog2 NUM_ANGLES)
// - DELAY_W         4   per-channel delay code width (matches delay line)
// - SETTLE_SAMPLES  17  sample strobes to wait after a commit before data is valid
// PORTS
// - clk         in   1                clock
// - rst         in   1                asynchronous, active-high reset
// - sample_en   in   1                one-cycle strobe per PCM sample (delay lines advance on it)
// - req_valid   in   1                steering request valid
// - req_angle   in   ANGLE_W          requested angle index
// - req_ready   out  1                request accepted when req_valid & req_ready
// - req_err     out  1                1-cycle pulse: accepted angle >= NUM_ANGLES, request ignored
// - delay_flat  out  NUM_CH*DELAY_W   committed delays; channel c at [c*DELAY_W +: DELAY_W]
// - cur_angle   out  ANGLE_W          angle of the currently committed delays
// - busy        out  1                high in any state other than IDLE
// - data_valid  out  1                beamformer output trustworthy (delays settled)
// BEHAVIOUR
// - Reset: delay_flat=0, cur_angle=0, req_ready=0, req_err=0, data_valid=0, FSM=SETTLE, settle count=0.
// - Reset mid-operation aborts any LOAD/WAIT and discards the shadow register.
// - IDLE: req_ready=1, data_valid=1.
//   - Handshake with req_angle<NUM_ANGLES: latch angle, ch_idx=0, go to LOAD.
//   - Handshake with an out-of-range angle: req_err=1 next cycle, stay IDLE, no output change.
// - LOAD: req_ready=0. The ROM read is registered (1 cycle), so shadow[ch] is written one cycle after address ch.
//   - Channel addresses are issued on consecutive cycles.
//   - The last shadow write lands NUM_CH+1 cycles after the accepting edge; then go to WAIT.
//   - sample_en is ignored in LOAD.
// - WAIT: on the first sample_en, delay_flat<=shadow and cur_angle<=latched angle on that same edge.
//   - data_valid<=0 and settle count=0 on that edge; go to SETTLE.
// - SETTLE: data_valid=0. Each sample_en increments the count.
//   - On the edge where count reaches SETTLE_SAMPLES: data_valid<=1, go to IDLE.
//   - The commit strobe itself is not counted.
// - delay_flat changes only on a commit edge; it never shows a partially loaded set.
// - A request equal to cur_angle is processed normally (reload, commit, settle); there is no shortcut.
// - Requests are never queued. req_valid held while busy is accepted on the first IDLE cycle.
// - Settle counter width is clog2(SETTLE_SAMPLES+1). It saturates and never wraps.
// - Default table: delay(a,c) = (a*c) mod 2^DELAY_W, truncated to DELAY_W bits.
// STRUCTURE
// - Package beam_pkg holds:
//   - FSM state enum {IDLE, LOAD, WAIT, SETTLE};
//   - DELAY_W, ANGLE_W and NUM_CH localparams;
//   - the default delay-table function delay_lut(angle, ch).
// - Sub-module beam_delay_rom: registered lookup (angle, ch) -> delay, 1-cycle latency.
// - Top level: FSM, channel index counter, shadow register array, commit register, settle counter.
// TESTING
// - Reset release, then 17 sample_en strobes: data_valid stays 0 through the 16th strobe and rises after the 17th.
//   - Throughout: delay_flat=0, busy=1 until IDLE.
// - Request angle 3 in IDLE with no sample_en for 20 cycles: req_ready drops and delay_flat is unchanged.
//   - Then one sample_en: delay_flat={9,6,3,0} (ch3..ch0), cur_angle=3, data_valid=0.
// - Request angle 5 while SETTLE from angle 3: req_ready=0 and the request is held.
//   - Accepted on the IDLE cycle; next commit gives delay_flat={15,10,5,0}.
// - Angle 7 with NUM_ANGLES=6: one-cycle req_err=1.
//   - State stays IDLE; delay_flat and cur_angle unchanged; data_valid stays 1.
// - sample_en pulsed every cycle during LOAD: no commit before the shadow is complete.
//   - The commit occurs on the first strobe in WAIT.
// - Assert rst during LOAD of angle 2: outputs return to reset values next cycle.
//   - delay_flat=0, the pending angle is lost, and the FSM restarts in SETTLE.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared types and constants for the beamformer steering controller.
// The default steering table is a pure function so the ROM stays generic.
package beam_pkg;

  localparam int NUM_CH  = 4;
  localparam int ANGLE_W = 3;
  localparam int DELAY_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    WAIT   = 2'd2,
    SETTLE = 2'd3
  } state_e;

  // delay(a, c) = a*c, wrapped to the delay-line code width
  function automatic int unsigned delay_lut(input int unsigned angle, input int unsigned ch);
    return (angle * ch) & ((32'd1 << DELAY_W) - 32'd1);
  endfunction

endpackage

// File: rtl/beam_delay_rom.sv
// Registered steering-table lookup: (angle, channel) -> delay code.
// Data appears one clock after the address is presented.
module beam_delay_rom
  import beam_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ANGLE_W-1:0]           angle_i,
  input  logic [$clog2(NUM_CH)-1:0]    ch_i,
  output logic [DELAY_W-1:0]           delay_o
);

  logic [31:0]        lut_full;
  logic [DELAY_W-1:0] delay_d;
  logic [DELAY_W-1:0] delay_q;

  assign lut_full = delay_lut(32'(angle_i), 32'(ch_i));
  assign delay_d  = lut_full[DELAY_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_q <= '0;
    end else begin
      delay_q <= delay_d;
    end
  end

  assign delay_o = delay_q;

endmodule

// File: rtl/beam_delay_scheduler.sv
// Steering controller: loads per-channel delays into a shadow set, commits
// them together on a sample strobe, then holds data_valid low while lines flush.
//
// state  | meaning
// IDLE   | delays settled, ready for a steering request
// LOAD   | reading the table into the shadow register, one channel per cycle
// WAIT   | shadow complete, committing on the next sample strobe
// SETTLE | counting sample strobes while the delay lines flush stale data
module beam_delay_scheduler
  import beam_pkg::*;
#(
  parameter int NUM_ANGLES     = 8,
  parameter int SETTLE_SAMPLES = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_en,
  input  logic                      req_valid,
  input  logic [ANGLE_W-1:0]        req_angle,
  output logic                      req_ready,
  output logic                      req_err,
  output logic [NUM_CH*DELAY_W-1:0] delay_flat,
  output logic [ANGLE_W-1:0]        cur_angle,
  output logic                      busy,
  output logic                      data_valid
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [CH_W:0]      CH_END  = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT = CNT_W'(SETTLE_SAMPLES);

  state_e                            state_q;
  logic [ANGLE_W-1:0]                angle_q;
  logic [CH_W:0]                     ch_idx_q;
  logic                              rd_vld_q;
  logic [CH_W-1:0]                   rd_ch_q;
  logic [NUM_CH-1:0][DELAY_W-1:0]    shadow_q;
  logic [NUM_CH-1:0][DELAY_W-1:0]    delay_flat_q;
  logic [ANGLE_W-1:0]                cur_angle_q;
  logic                              req_ready_q;
  logic                              req_err_q;
  logic                              data_valid_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CNT_W-1:0]                  cnt_d;
  logic [DELAY_W-1:0]                rom_data;
  logic                              angle_ok;

  beam_delay_rom u_rom (
    .clk     (clk),
    .rst     (rst),
    .angle_i (angle_q),
    .ch_i    (ch_idx_q[CH_W-1:0]),
    .delay_o (rom_data)
  );

  assign angle_ok = (32'(req_angle) < 32'(NUM_ANGLES));
  assign cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SETTLE;
      angle_q      <= '0;
      ch_idx_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_ch_q      <= '0;
      shadow_q     <= '0;
      delay_flat_q <= '0;
      cur_angle_q  <= '0;
      req_ready_q  <= 1'b0;
      req_err_q    <= 1'b0;
      data_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      req_err_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            if (angle_ok) begin
              angle_q     <= req_angle;
              ch_idx_q    <= '0;
              req_ready_q <= 1'b0;
              state_q     <= LOAD;
            end else begin
              req_err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          // Address issue and shadow write run one cycle apart (ROM latency)
          if (ch_idx_q != CH_END) begin
            rd_vld_q <= 1'b1;
            rd_ch_q  <= ch_idx_q[CH_W-1:0];
            ch_idx_q <= ch_idx_q + 1'b1;
          end
          if (rd_vld_q) begin
            shadow_q[rd_ch_q] <= rom_data;
            if (rd_ch_q == CH_LAST) begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (sample_en) begin
            delay_flat_q <= shadow_q;
            cur_angle_q  <= angle_q;
            data_valid_q <= 1'b0;
            cnt_q        <= '0;
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          if (sample_en) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_SAT) begin
              data_valid_q <= 1'b1;
              req_ready_q  <= 1'b1;
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= SETTLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign req_err    = req_err_q;
  assign delay_flat = delay_flat_q;
  assign cur_angle  = cur_angle_q;
  assign busy       = (state_q != IDLE);
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_beam_delay_scheduler.sv
// Directed bench for beam_delay_scheduler: expected commits are queued when a
// request is driven and popped when the commit strobe lands.
module tb_beam_delay_scheduler;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic        req_valid;
  logic [2:0]  req_angle;
  logic        req_ready;
  logic        req_err;
  logic [15:0] delay_flat;
  logic [2:0]  cur_angle;
  logic        busy;
  logic        data_valid;

  typedef struct {
    logic [2:0]  angle;
    logic [15:0] flat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  beam_delay_scheduler #(
    .NUM_ANGLES     (6),
    .SETTLE_SAMPLES (17)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_ready  (req_ready),
    .req_err    (req_err),
    .delay_flat (delay_flat),
    .cur_angle  (cur_angle),
    .busy       (busy),
    .data_valid (data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_flat(input int a);
    logic [15:0] f;
    f = '0;
    for (int c = 0; c < 4; c++) f[c*4 +: 4] = 4'((a * c) % 16);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse sample_en for one posedge; returns at the following negedge.
  task automatic strobe();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_flat"},  32'(delay_flat), 32'h0);
    chk({tag, "_angle"}, 32'(cur_angle),  32'h0);
    chk({tag, "_ready"}, 32'(req_ready),  32'h0);
    chk({tag, "_err"},   32'(req_err),    32'h0);
    chk({tag, "_dv"},    32'(data_valid), 32'h0);
    chk({tag, "_busy"},  32'(busy),       32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_en = 1'b0; req_valid = 1'b0; req_angle = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;

    // Initial settle after reset
    for (int i = 1; i <= 17; i++) begin
      strobe();
      chk("init_dv",   32'(data_valid), 32'(i == 17));
      chk("init_busy", 32'(busy),       32'(i < 17));
      chk("init_flat", 32'(delay_flat), 32'h0);
    end
    chk("init_ready", 32'(req_ready), 32'h1);

    // Angle 3, no strobes for 20 cycles, then commit
    req_valid = 1'b1; req_angle = 3'd3;
    exp_q.push_back('{angle: 3'd3, flat: model_flat(3)});
    @(negedge clk);
    req_valid = 1'b0;
    chk("a3_ready", 32'(req_ready), 32'h0);
    chk("a3_busy",  32'(busy),      32'h1);
    repeat (20) @(negedge clk);
    chk("a3_hold_flat",  32'(delay_flat), 32'h0);
    chk("a3_hold_angle", 32'(cur_angle),  32'h0);
    chk("a3_hold_dv",    32'(data_valid), 32'h1);
    strobe();
    e = exp_q.pop_front();
    chk("a3_commit_flat",  32'(delay_flat), 32'(e.flat));
    chk("a3_commit_angle", 32'(cur_angle),  32'(e.angle));
    chk("a3_commit_dv",    32'(data_valid), 32'h0);

    // Angle 5 requested during SETTLE and held
    req_valid = 1'b1; req_angle = 3'd5;
    exp_q.push_back('{angle: 3'd5, flat: model_flat(5)});
    @(negedge clk);
    chk("a5_held_ready", 32'(req_ready), 32'h0);
    for (int i = 1; i <= 17; i++) begin
      strobe();
      if (i < 17) begin
        chk("a5_settle_ready", 32'(req_ready), 32'h0);
        chk("a5_settle_dv",    32'(data_valid), 32'h0);
      end
    end
    chk("a5_idle_dv",    32'(data_valid), 32'h1);
    chk("a5_idle_ready", 32'(req_ready),  32'h1);
    chk("a5_idle_busy",  32'(busy),       32'h0);

    // Accept on the IDLE cycle with sample_en strobing every cycle through LOAD
    sample_en = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("a5_acc_ready", 32'(req_ready),  32'h0);
    chk("a5_acc_busy",  32'(busy),       32'h1);
    chk("a5_acc_dv",    32'(data_valid), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("a5_no_early_commit", 32'(delay_flat), 32'(model_flat(3)));
    end
    @(negedge clk);
    sample_en = 1'b0;
    e = exp_q.pop_front();
    chk("a5_commit_flat",  32'(delay_flat), 32'(e.flat));
    chk("a5_commit_angle", 32'(cur_angle),  32'(e.angle));
    chk("a5_commit_dv",    32'(data_valid), 32'h0);
    for (int i = 1; i <= 17; i++) begin
      strobe();
      chk("a5_settle2_dv", 32'(data_valid), 32'(i == 17));
    end

    // Out-of-range angle
    req_valid = 1'b1; req_angle = 3'd7;
    @(negedge clk);
    req_valid = 1'b0;
    chk("err_pulse", 32'(req_err),    32'h1);
    chk("err_ready", 32'(req_ready),  32'h1);
    chk("err_busy",  32'(busy),       32'h0);
    chk("err_flat",  32'(delay_flat), 32'(model_flat(5)));
    chk("err_angle", 32'(cur_angle),  32'h5);
    chk("err_dv",    32'(data_valid), 32'h1);
    @(negedge clk);
    chk("err_clear", 32'(req_err), 32'h0);

    // Reset during LOAD of angle 2
    req_valid = 1'b1; req_angle = 3'd2;
    @(negedge clk);
    req_valid = 1'b0;
    chk("a2_busy", 32'(busy), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      strobe();
      chk("post_rst_dv", 32'(data_valid), 32'(i == 17));
    end
    chk("post_rst_flat",  32'(delay_flat), 32'h0);
    chk("post_rst_angle", 32'(cur_angle),  32'h0);
    chk("post_rst_ready", 32'(req_ready),  32'h1);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
